// File: rtl/mul53_arbiter_if.sv
// Request/response bundle between the requesting units and the shared
// 53x53 multiplier wrapper. The arbiter is the slave; requesters are the master.
interface mul53_arbiter_if #(
    parameter int NREQ = 2,
    parameter int TAGW = 4
);
    logic [NREQ-1:0]      reqValid;
    logic [NREQ-1:0]      reqReady;
    logic [NREQ-1:0]      reqSigned;
    logic [NREQ*53-1:0]   reqA;
    logic [NREQ*53-1:0]   reqB;
    logic [NREQ*TAGW-1:0] reqTag;
    logic [NREQ-1:0]      respValid;
    logic [NREQ-1:0]      respReady;
    logic [105:0]         respProduct;
    logic [TAGW-1:0]      respTag;

    modport slave (
        input  reqValid, reqSigned, reqA, reqB, reqTag, respReady,
        output reqReady, respValid, respProduct, respTag
    );

    modport master (
        output reqValid, reqSigned, reqA, reqB, reqTag, respReady,
        input  reqReady, respValid, respProduct, respTag
    );
endinterface

// File: rtl/mul53_arbiter.sv
// Two-stage wrapper sharing one 53x53 multiplier between NREQ requesters:
// round-robin grant into an operand stage, product captured in a result stage.
module mul53_arbiter #(
    parameter int NREQ = 2,
    parameter int TAGW = 4
) (
    input  logic           clk,
    input  logic           rstN,
    mul53_arbiter_if.slave bus
);
    localparam int PTRW = (NREQ > 2) ? 2 : 1;

    // Sign/zero extension to the full product width makes the modular product exact.
    function automatic logic [105:0] mul53(input logic sgn, input logic [52:0] a, input logic [52:0] b);
        logic [105:0] ea;
        logic [105:0] eb;
        ea = {{53{sgn & a[52]}}, a};
        eb = {{53{sgn & b[52]}}, b};
        return ea * eb;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [52:0]       s1_a_q, s1_a_d;
    logic [52:0]       s1_b_q, s1_b_d;
    logic              s1_signed_q, s1_signed_d;
    logic [TAGW-1:0]   s1_tag_q, s1_tag_d;
    logic [NREQ-1:0]   s1_owner_q, s1_owner_d;
    logic [NREQ-1:0]   s2_valid_q, s2_valid_d;
    logic [105:0]      s2_product_q, s2_product_d;
    logic [TAGW-1:0]   s2_tag_q, s2_tag_d;
    logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;

    logic              s2_drain_s, s2_load_s, s1_load_s, accept_s, win_found_s;
    logic [NREQ-1:0]   win_oh_s;
    logic [PTRW-1:0]   win_idx_s, nxt_ptr_s;
    int                best_dist_s, dist_s;
    logic [52:0]       sel_a_s, sel_b_s;
    logic              sel_signed_s;
    logic [TAGW-1:0]   sel_tag_s;

    // Round-robin pick: smallest distance from rr_ptr_q among valid requesters.
    always_comb begin
        win_found_s  = 1'b0;
        win_oh_s     = '0;
        win_idx_s    = '0;
        best_dist_s  = NREQ;
        dist_s       = 0;
        sel_a_s      = '0;
        sel_b_s      = '0;
        sel_signed_s = 1'b0;
        sel_tag_s    = '0;
        for (int r = 0; r < NREQ; r++) begin
            dist_s = (r + NREQ - int'(rr_ptr_q)) % NREQ;
            if (bus.reqValid[r] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                win_found_s = 1'b1;
                win_oh_s    = NREQ'(1'b1) << r;
                win_idx_s   = PTRW'(r);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            sel_a_s      = sel_a_s | (bus.reqA[r*53 +: 53] & {53{win_oh_s[r]}});
            sel_b_s      = sel_b_s | (bus.reqB[r*53 +: 53] & {53{win_oh_s[r]}});
            sel_signed_s = sel_signed_s | (bus.reqSigned[r] & win_oh_s[r]);
            sel_tag_s    = sel_tag_s | (bus.reqTag[r*TAGW +: TAGW] & {TAGW{win_oh_s[r]}});
        end
    end

    // Stage enables and next-state for both pipeline stages and the grant pointer.
    always_comb begin
        s2_drain_s   = |(s2_valid_q & bus.respReady);
        s2_load_s    = ~(|s2_valid_q) | s2_drain_s;
        s1_load_s    = ~s1_valid_q | s2_load_s;
        accept_s     = win_found_s & s1_load_s;
        nxt_ptr_s    = PTRW'((int'(win_idx_s) + 1) % NREQ);
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_signed_d  = s1_signed_q;
        s1_tag_d     = s1_tag_q;
        s1_owner_d   = s1_owner_q;
        s2_valid_d   = s2_valid_q;
        s2_product_d = s2_product_q;
        s2_tag_d     = s2_tag_q;
        rr_ptr_d     = rr_ptr_q;
        if (s1_load_s) begin
            s1_valid_d = accept_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (accept_s) begin
            s1_a_d      = sel_a_s;
            s1_b_d      = sel_b_s;
            s1_signed_d = sel_signed_s;
            s1_tag_d    = sel_tag_s;
            s1_owner_d  = win_oh_s;
            rr_ptr_d    = nxt_ptr_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (s2_load_s && s1_valid_q) begin
            s2_valid_d   = s1_owner_q;
            s2_product_d = mul53(s1_signed_q, s1_a_q, s1_b_q);
            s2_tag_d     = s1_tag_q;
        end else if (s2_load_s) begin
            s2_valid_d = '0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_signed_q  <= 1'b0;
            s1_tag_q     <= '0;
            s1_owner_q   <= '0;
            s2_valid_q   <= '0;
            s2_product_q <= '0;
            s2_tag_q     <= '0;
            rr_ptr_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_signed_q  <= s1_signed_d;
            s1_tag_q     <= s1_tag_d;
            s1_owner_q   <= s1_owner_d;
            s2_valid_q   <= s2_valid_d;
            s2_product_q <= s2_product_d;
            s2_tag_q     <= s2_tag_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.reqReady    = (rstN && accept_s) ? win_oh_s : '0;
    assign bus.respValid   = s2_valid_q;
    assign bus.respProduct = s2_product_q;
    assign bus.respTag     = s2_tag_q;
endmodule

// File: tb/tb_mul53_arbiter.sv
// Randomised and directed bench for mul53_arbiter against an in-order queue model.
module tb_mul53_arbiter;
    localparam int NREQ = 2;
    localparam int TAGW = 4;
    localparam logic [52:0] ALL1 = {53{1'b1}};

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    mul53_arbiter_if #(.NREQ(NREQ), .TAGW(TAGW)) bus();
    mul53_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (.clk(clk), .rstN(rstN), .bus(bus.slave));

    typedef struct {
        logic [105:0]    prod;
        logic [TAGW-1:0] tag;
        int              owner;
        bit              vis;
    } op_t;

    op_t q[$];
    int  m_ptr = 0;
    int  dut_acc[$];
    int  n_resp = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiply by magnitudes and fix the sign afterwards.
    function automatic logic [105:0] ref_mul(input bit s, input logic [52:0] a, input logic [52:0] b);
        bit na, nb;
        logic [52:0] ma, mb;
        logic [105:0] p;
        na = s && a[52];
        nb = s && b[52];
        ma = na ? (~a + 53'd1) : a;
        mb = nb ? (~b + 53'd1) : b;
        p = {53'd0, ma} * {53'd0, mb};
        if (na != nb) p = ~p + 106'd1;
        return p;
    endfunction

    function automatic int m_winner(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int r;
            r = (m_ptr + k) % NREQ;
            if (((v >> r) & 1'b1) != 0) return r;
        end
        return -1;
    endfunction

    function automatic logic [52:0] rand53();
        int unsigned k;
        k = $urandom_range(0, 7);
        if (k == 0) return ALL1;
        if (k == 1) return 53'd0;
        if (k == 2) return 53'd1 << 52;
        return 53'({$urandom(), $urandom()});
    endfunction

    task automatic set_req(input int r, input bit v, input bit s, input logic [52:0] a,
                           input logic [52:0] b, input logic [TAGW-1:0] t);
        bus.reqValid[r]            = v;
        bus.reqSigned[r]           = s;
        bus.reqA[r*53 +: 53]       = a;
        bus.reqB[r*53 +: 53]       = b;
        bus.reqTag[r*TAGW +: TAGW] = t;
    endtask

    // Compare against the model on every falling edge, then advance it for the next rising edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rstN) begin
                chk("rst_reqReady", bus.reqReady, 128'd0);
                chk("rst_respValid", bus.respValid, 128'd0);
                chk("rst_respProduct", bus.respProduct, 128'd0);
                chk("rst_respTag", bus.respTag, 128'd0);
                q.delete();
                m_ptr = 0;
            end else begin
                int w;
                bit dr, acc;
                logic [NREQ-1:0] er, ev;
                op_t n;
                w  = m_winner(bus.reqValid);
                dr = 1'b0;
                ev = '0;
                if (q.size() > 0) begin
                    if (q[0].vis) begin
                        ev = NREQ'(1'b1) << q[0].owner;
                        dr = ((bus.respReady >> q[0].owner) & 1'b1) != 0;
                    end
                end
                acc = (w >= 0) && ((q.size() < 2) || dr);
                er  = acc ? (NREQ'(1'b1) << w) : '0;
                chk("reqReady", bus.reqReady, er);
                chk("respValid", bus.respValid, ev);
                if (ev != 0) begin
                    chk("respProduct", bus.respProduct, q[0].prod);
                    chk("respTag", bus.respTag, q[0].tag);
                end
                for (int r = 0; r < NREQ; r++)
                    if (bus.reqValid[r] && bus.reqReady[r]) dut_acc.push_back(r);
                if (|(bus.respValid & bus.respReady)) n_resp++;
                if (dr) void'(q.pop_front());
                if (q.size() > 0) q[0].vis = 1'b1;
                if (acc) begin
                    n.prod  = ref_mul(bus.reqSigned[w], bus.reqA[w*53 +: 53], bus.reqB[w*53 +: 53]);
                    n.tag   = bus.reqTag[w*TAGW +: TAGW];
                    n.owner = w;
                    n.vis   = 1'b0;
                    q.push_back(n);
                    m_ptr = (w + 1) % NREQ;
                end
            end
        end
    end

    task automatic single_op(input string name, input int r, input bit s, input logic [52:0] a,
                             input logic [52:0] b, input logic [TAGW-1:0] t,
                             input logic [NREQ-1:0] exp_v, input logic [105:0] exp_p);
        set_req(r, 1'b1, s, a, b, t);
        @(posedge clk); #1;
        bus.reqValid = '0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_respValid"}, bus.respValid, exp_v);
        chk({name, "_product"}, bus.respProduct, exp_p);
        chk({name, "_tag"}, bus.respTag, t);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int cnt, start, r0, a0;
        bit held;
        logic [105:0] hold_p, lit;
        logic [TAGW-1:0] hold_t;

        rstN = 1'b0;
        bus.reqValid = '0; bus.reqSigned = '0; bus.reqA = '0; bus.reqB = '0; bus.reqTag = '0;
        bus.respReady = 2'b11;

        lit = 106'd1;
        chk("model_signed_m1xm1", ref_mul(1'b1, ALL1, ALL1), lit);
        lit = ({106{1'b1}} << 54) | 106'd1;
        chk("model_unsigned_max", ref_mul(1'b0, ALL1, ALL1), lit);
        lit = ~106'd2;
        chk("model_mixed_3xm1", ref_mul(1'b1, 53'd3, ALL1), lit);

        bus.reqValid = 2'b11;
        #3;
        chk("init_reqReady", bus.reqReady, 128'd0);
        chk("init_respValid", bus.respValid, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        bus.reqValid = '0;
        rstN = 1'b1;

        single_op("signed_m1", 0, 1'b1, ALL1, ALL1, 4'd5, 2'b01, 106'd1);
        lit = ({106{1'b1}} << 54) | 106'd1;
        single_op("unsigned_max", 1, 1'b0, ALL1, ALL1, 4'd9, 2'b10, lit);
        lit = ~106'd2;
        single_op("mixed_sign", 0, 1'b1, 53'd3, ALL1, 4'd3, 2'b01, lit);

        // Round robin straight out of reset.
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        start = dut_acc.size();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, 1'($urandom_range(0, 1)), rand53(), rand53(), TAGW'(i));
            set_req(1, 1'b1, 1'($urandom_range(0, 1)), rand53(), rand53(), TAGW'(8 + i));
            @(negedge clk);
            if (|(bus.respValid & bus.respReady)) cnt++;
            @(posedge clk); #1;
        end
        bus.reqValid = '0;
        chk("rr_accept_count", dut_acc.size() - start, 8);
        for (int i = 0; i < 8; i++)
            if (start + i < dut_acc.size()) chk("rr_order", dut_acc[start + i], i % 2);
        chk("rr_throughput", cnt, 6);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure on requester 0.
        r0 = n_resp;
        a0 = dut_acc.size();
        bus.respReady = 2'b00;
        cnt = 0;
        held = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1'b1, 1'($urandom_range(0, 1)), rand53(), rand53(), TAGW'($urandom));
            @(negedge clk);
            if (bus.reqValid[0] && bus.reqReady[0]) cnt++;
            if (bus.respValid[0]) begin
                if (held) begin
                    chk("bp_hold_product", bus.respProduct, hold_p);
                    chk("bp_hold_tag", bus.respTag, hold_t);
                end
                hold_p = bus.respProduct;
                hold_t = bus.respTag;
                held = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepts", cnt, 2);
        chk("bp_full_ready", bus.reqReady, 2'b00);
        bus.respReady = 2'b11;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 1'($urandom_range(0, 1)), rand53(), rand53(), TAGW'($urandom));
            @(posedge clk); #1;
        end
        bus.reqValid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_loss", n_resp - r0, dut_acc.size() - a0);

        // Reset with two operations in flight.
        bus.respReady = 2'b00;
        set_req(0, 1'b1, 1'b0, rand53(), rand53(), 4'd7);
        repeat (2) @(posedge clk);
        #1;
        bus.reqValid = '0;
        @(posedge clk); #1;
        rstN = 1'b0;
        bus.reqValid = 2'b11;
        #1;
        chk("mid_rst_respValid", bus.respValid, 2'b00);
        chk("mid_rst_reqReady", bus.reqReady, 2'b00);
        @(posedge clk); #1;
        rstN = 1'b1;
        bus.reqValid = '0;
        bus.respReady = 2'b11;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (|bus.respValid) cnt++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_resp", cnt, 0);
        bus.reqValid = 2'b11;
        #1;
        chk("mid_rst_first_grant", bus.reqReady, 2'b01);
        @(posedge clk); #1;
        bus.reqValid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                set_req(r, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand53(), rand53(),
                        TAGW'($urandom));
                bus.respReady[r] = $urandom_range(0, 3) != 0;
            end
            @(posedge clk); #1;
        end
        bus.reqValid = '0;
        bus.respReady = 2'b11;
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
